// File: rtl/game_pkg.sv
// Shared key-polarity constants and the auto-repeat state encoding used by the
// key conditioning logic.
package game_pkg;

    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    typedef enum logic [1:0] {
        REL       = 2'd0,
        HELD_WAIT = 2'd1,
        HELD_RPT  = 2'd2
    } rpt_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: two-flop synchroniser, debounce counter that accepts a new
// level after DEBOUNCE_CYCLES stable cycles, and press/release/auto-repeat strobes.
module key_chan
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_i,
    output logic key_level_o,
    output logic key_press_o,
    output logic key_release_o,
    output logic key_rpt_o
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned RW = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE));
    localparam logic [DW-1:0] D_TERM  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_TERM = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RR_TERM = RW'(REPEAT_RATE - 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic          level_d;
    logic [DW-1:0] dcnt_q;
    logic [DW-1:0] dcnt_d;
    logic          differ;
    logic          accept;
    logic          acc_press;
    logic          acc_release;
    rpt_state_e    state_q;
    logic [RW-1:0] rcnt_q;
    logic          press_q;
    logic          release_q;
    logic          rpt_q;

    // The counter only increments below its terminal value, so it cannot wrap.
    always_comb begin
        differ      = (sync_q[1] != level_q);
        accept      = differ && (dcnt_q == D_TERM);
        acc_press   = accept && (sync_q[1] == KEY_PRESSED);
        acc_release = accept && (sync_q[1] == KEY_RELEASED);
        level_d     = accept ? sync_q[1] : level_q;
        dcnt_d      = dcnt_q;
        if (!differ || accept) begin
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= {KEY_RELEASED, KEY_RELEASED};
            level_q   <= KEY_RELEASED;
            dcnt_q    <= '0;
            state_q   <= REL;
            rcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rpt_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_raw_i};
            level_q   <= level_d;
            dcnt_q    <= dcnt_d;
            press_q   <= acc_press;
            release_q <= acc_release;
            rpt_q     <= 1'b0;
            case (state_q)
                REL: begin
                    rcnt_q <= '0;
                    if (acc_press) begin
                        state_q <= HELD_WAIT;
                    end
                end
                HELD_WAIT: begin
                    // A release wins over a repeat due in the same cycle.
                    if (acc_release) begin
                        state_q <= REL;
                        rcnt_q  <= '0;
                    end else if (rcnt_q == RD_TERM) begin
                        state_q <= HELD_RPT;
                        rcnt_q  <= '0;
                        rpt_q   <= 1'b1;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end
                HELD_RPT: begin
                    if (acc_release) begin
                        state_q <= REL;
                        rcnt_q  <= '0;
                    end else if (rcnt_q == RR_TERM) begin
                        rcnt_q <= '0;
                        rpt_q  <= 1'b1;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= REL;
                    rcnt_q  <= '0;
                end
            endcase
        end
    end

    assign key_level_o   = level_q;
    assign key_press_o   = press_q;
    assign key_release_o = release_q;
    assign key_rpt_o     = rpt_q;

endmodule

// File: rtl/key_cond.sv
// Key conditioner: N_KEYS independent debounced channels with press, release,
// auto-repeat and menu-step strobes.
module key_cond #(
    parameter int unsigned N_KEYS          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_rpt,
    output logic [N_KEYS-1:0] key_step
);

    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
            key_chan #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_RATE    (REPEAT_RATE)
            ) u_chan (
                .clk          (clk),
                .rst_n        (rst_n),
                .key_raw_i    (key_raw[gi]),
                .key_level_o  (key_level[gi]),
                .key_press_o  (key_press[gi]),
                .key_release_o(key_release[gi]),
                .key_rpt_o    (key_rpt[gi])
            );
        end
    endgenerate

    assign key_step = key_press | key_rpt;

endmodule

// File: tb/tb_key_cond.sv
// Self-checking bench for key_cond: expected strobe events are derived from the
// timing rules and pushed to a queue, then matched against observed strobes.
module tb_key_cond;

    localparam int N   = 2;
    localparam int D   = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;
    localparam int LAT = 2 + D;
    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_RPT   = 2;
    localparam int K_STEP  = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] key_raw = '1;
    logic [N-1:0] key_level, key_press, key_release, key_rpt, key_step;

    int cyc = 0;
    int n_cmp = 0;
    int n_mis = 0;
    int exp_q[$];
    int obs_q[$];

    key_cond #(
        .N_KEYS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .key_level(key_level),
        .key_press(key_press), .key_release(key_release), .key_rpt(key_rpt),
        .key_step(key_step)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe seen becomes an event code cycle*16 + key*4 + kind.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (key_press[k])   obs_q.push_back(cyc * 16 + k * 4 + K_PRESS);
            if (key_release[k]) obs_q.push_back(cyc * 16 + k * 4 + K_REL);
            if (key_rpt[k])     obs_q.push_back(cyc * 16 + k * 4 + K_RPT);
            if (key_step[k])    obs_q.push_back(cyc * 16 + k * 4 + K_STEP);
        end
    end

    function automatic string ev_str(input int e);
        string kn;
        case (e % 4)
            K_PRESS: kn = "press";
            K_REL:   kn = "release";
            K_RPT:   kn = "rpt";
            default: kn = "step";
        endcase
        return $sformatf("cyc%0d/key%0d/%s", e / 16, (e / 4) % 4, kn);
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_ev(input int c, input int k, input int kind);
        exp_q.push_back(c * 16 + k * 4 + kind);
        if (kind == K_PRESS || kind == K_RPT) exp_q.push_back(c * 16 + k * 4 + K_STEP);
    endtask

    // Raw key k low from cycle cd to cycle cu: press, repeats strictly before
    // the release cycle, then release.
    task automatic push_hold(input int k, input int cd, input int cu);
        push_ev(cd + LAT, k, K_PRESS);
        for (int r = cd + LAT + RD; r < cu + LAT; r += RR) push_ev(r, k, K_RPT);
        push_ev(cu + LAT, k, K_REL);
    endtask

    task automatic test_reset();
        int c, e, o;
        rst_n = 1'b0;
        key_raw = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({key_level, key_press, key_release, key_rpt, key_step} !== 10'b11_00_00_00_00) begin
                n_mis++;
                $display("FAIL reset_state: got lvl=%b prs=%b rel=%b rpt=%b stp=%b, expected lvl=11 rest 00",
                         key_level, key_press, key_release, key_rpt, key_step);
            end
        end
        obs_q.delete();
        c = cyc;
        rst_n = 1'b1;
        push_ev(c + LAT, 0, K_PRESS);
        push_ev(c + LAT, 1, K_PRESS);
        wait_until(c + LAT - 1);
        n_cmp++;
        if (key_level !== 2'b11) begin
            n_mis++;
            $display("FAIL reset_level_early: got %b, expected 11", key_level);
        end
        wait_until(c + LAT);
        n_cmp++;
        if (key_level !== 2'b00) begin
            n_mis++;
            $display("FAIL reset_level_held: got %b, expected 00", key_level);
        end
        wait_until(c + 7);
        key_raw = 2'b11;
        push_ev(c + 7 + LAT, 0, K_REL);
        push_ev(c + 7 + LAT, 1, K_REL);
        wait_until(c + 30);
        exp_q.sort(); obs_q.sort();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_mis++;
            $display("FAIL reset count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = -1;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_mis++;
                $display("FAIL reset event: got %s, expected %s", (o < 0) ? "none" : ev_str(o), ev_str(e));
            end
        end
        obs_q.delete();
    endtask

    task automatic test_bounce();
        obs_q.delete();
        for (int i = 0; i < 5; i++) begin
            key_raw[0] = 1'b0;
            repeat (D - 1) @(negedge clk);
            key_raw[0] = 1'b1;
            repeat (D - 1) @(negedge clk);
            n_cmp++;
            if (key_level[0] !== 1'b1) begin
                n_mis++;
                $display("FAIL bounce_level: got %b, expected 1", key_level[0]);
            end
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_mis++;
            $display("FAIL bounce count: got %0d strobes (first %s), expected 0", obs_q.size(), ev_str(obs_q[0]));
        end
        obs_q.delete();
    endtask

    task automatic test_press_release();
        int c, e, o;
        obs_q.delete();
        c = cyc;
        key_raw[0] = 1'b0;
        wait_until(c + 8);
        key_raw[0] = 1'b1;
        push_hold(0, c, c + 8);
        wait_until(c + LAT);
        n_cmp++;
        if (key_level !== 2'b10) begin
            n_mis++;
            $display("FAIL press_level: got %b, expected 10", key_level);
        end
        wait_until(c + 30);
        exp_q.sort(); obs_q.sort();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_mis++;
            $display("FAIL press_release count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = -1;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_mis++;
                $display("FAIL press_release event: got %s, expected %s", (o < 0) ? "none" : ev_str(o), ev_str(e));
            end
        end
        obs_q.delete();
    endtask

    task automatic test_repeat();
        int c, e, o;
        obs_q.delete();
        c = cyc;
        key_raw[1] = 1'b0;
        wait_until(c + 40);
        key_raw[1] = 1'b1;
        push_hold(1, c, c + 40);
        wait_until(c + 60);
        exp_q.sort(); obs_q.sort();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_mis++;
            $display("FAIL repeat count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = -1;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_mis++;
                $display("FAIL repeat event: got %s, expected %s", (o < 0) ? "none" : ev_str(o), ev_str(e));
            end
        end
        obs_q.delete();
    endtask

    // Release accepted exactly when the first repeat-rate period expires.
    task automatic test_release_terminal();
        int c, e, o;
        obs_q.delete();
        c = cyc;
        key_raw[0] = 1'b0;
        wait_until(c + RD + RR);
        key_raw[0] = 1'b1;
        push_hold(0, c, c + RD + RR);
        wait_until(c + 35);
        exp_q.sort(); obs_q.sort();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_mis++;
            $display("FAIL release_terminal count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = -1;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_mis++;
                $display("FAIL release_terminal event: got %s, expected %s", (o < 0) ? "none" : ev_str(o), ev_str(e));
            end
        end
        obs_q.delete();
    endtask

    task automatic test_independence();
        int c, e, o;
        obs_q.delete();
        c = cyc;
        key_raw[0] = 1'b0;
        wait_until(c + 2);
        key_raw[1] = 1'b0;
        wait_until(c + 20);
        key_raw[0] = 1'b1;
        wait_until(c + 31);
        key_raw[1] = 1'b1;
        push_hold(0, c, c + 20);
        push_hold(1, c + 2, c + 31);
        wait_until(c + 50);
        exp_q.sort(); obs_q.sort();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_mis++;
            $display("FAIL independence count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = -1;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_mis++;
                $display("FAIL independence event: got %s, expected %s", (o < 0) ? "none" : ev_str(o), ev_str(e));
            end
        end
        obs_q.delete();
    endtask

    // Reset while a key is held mid-repeat: outputs clear at once, nothing fires after.
    task automatic test_reset_abort();
        int c, e, o;
        obs_q.delete();
        c = cyc;
        key_raw[1] = 1'b0;
        push_ev(c + LAT, 1, K_PRESS);
        wait_until(c + 12);
        rst_n = 1'b0;
        key_raw = 2'b11;
        #1;
        n_cmp++;
        if ({key_level, key_press, key_release, key_rpt, key_step} !== 10'b11_00_00_00_00) begin
            n_mis++;
            $display("FAIL abort_state: got lvl=%b prs=%b rel=%b rpt=%b stp=%b, expected lvl=11 rest 00",
                     key_level, key_press, key_release, key_rpt, key_step);
        end
        wait_until(c + 15);
        rst_n = 1'b1;
        wait_until(c + 40);
        exp_q.sort(); obs_q.sort();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_mis++;
            $display("FAIL reset_abort count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = -1;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_mis++;
                $display("FAIL reset_abort event: got %s, expected %s", (o < 0) ? "none" : ev_str(o), ev_str(e));
            end
        end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_press_release();
        test_repeat();
        test_release_terminal();
        test_independence();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion earlier", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
